// File: rtl/pipeline_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and constants for the pipeline sequencer
package pipe_ctrl_pkg;
  typedef enum logic {RUN = 1'b0, REDIRECT = 1'b1} state_t;
  localparam int PIPE_CTRL_MEM_TIMEOUT_DEF = 64;
  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs and pipeline-register controls around the sequencer
interface pipeline_ctrl_if;
  logic id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic id_uses_rs1;
  logic id_uses_rs2;
  logic ex_valid;
  logic ex_mem_read;
  logic [4:0] ex_rd;
  logic ex_branch_taken;
  logic imem_ready;
  logic mem_req;
  logic mem_ack;
  logic stall_if;
  logic flush_if_id;
  logic bubble_id_ex;
  logic stall_id_ex;
  logic stall_ex_mem;
  logic bubble_mem_wb;
  logic mem_timeout;
  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_valid, ex_mem_read, ex_rd,
           ex_branch_taken, imem_ready, mem_req, mem_ack,
    input  stall_if, flush_if_id, bubble_id_ex, stall_id_ex, stall_ex_mem, bubble_mem_wb, mem_timeout
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_valid, ex_mem_read, ex_rd,
           ex_branch_taken, imem_ready, mem_req, mem_ack,
    output stall_if, flush_if_id, bubble_id_ex, stall_id_ex, stall_ex_mem, bubble_mem_wb, mem_timeout
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator between the load in EX and the instruction in ID
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       load_use
);
  assign load_use = ex_valid && ex_mem_read && ex_rd != REG_X0 && id_valid &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: 5-stage pipeline sequencer (mem-wait freeze, branch redirect, load-use); PIPE_CTRL_PERF_EN adds perf counters
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = PIPE_CTRL_MEM_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  pipeline_ctrl_if.slave bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_load_use,
  output logic [31:0] perf_flush,
  output logic [31:0] perf_mem_wait
`endif
);
  localparam logic [15:0] LAST = 16'(MEM_TIMEOUT - 1);
  state_t state;
  logic [15:0] wait_cnt;
  logic load_use, mem_busy, freeze, timeout, lu_bubble, flush;
  hazard_detect u_hazard (
    .ex_valid   (bus.ex_valid),
    .ex_mem_read(bus.ex_mem_read),
    .ex_rd      (bus.ex_rd),
    .id_valid   (bus.id_valid),
    .id_rs1     (bus.id_rs1),
    .id_rs2     (bus.id_rs2),
    .id_uses_rs1(bus.id_uses_rs1),
    .id_uses_rs2(bus.id_uses_rs2),
    .load_use   (load_use)
  );
  // Hazard arbitration: freeze beats branch, branch beats load-use; everything gated off in reset
  always_comb begin
    mem_busy = bus.mem_req && !bus.mem_ack;
    freeze = mem_busy && wait_cnt < LAST;
    timeout = mem_busy && wait_cnt == LAST;
    lu_bubble = !freeze && !bus.ex_branch_taken && state == RUN && load_use;
    flush = !freeze && (bus.ex_branch_taken || state == REDIRECT);
    bus.stall_if = reset_n && (freeze || lu_bubble);
    bus.flush_if_id = reset_n && flush;
    bus.bubble_id_ex = reset_n && !freeze && (bus.ex_branch_taken || lu_bubble);
    bus.stall_id_ex = reset_n && freeze;
    bus.stall_ex_mem = reset_n && freeze;
    bus.bubble_mem_wb = reset_n && (freeze || timeout);
    bus.mem_timeout = reset_n && timeout;
  end
  // Redirect FSM and data-memory wait counter; a freeze holds the state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= freeze ? wait_cnt + 16'd1 : 16'd0;
      if (!freeze)
        state <= bus.ex_branch_taken ? (bus.imem_ready ? RUN : REDIRECT) :
                 (state == REDIRECT && bus.imem_ready) ? RUN : state;
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  // Saturating event counters for load-use bubbles, flush cycles and freeze cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_load_use <= '0;
      perf_flush <= '0;
      perf_mem_wait <= '0;
    end else begin
      if (lu_bubble && !(&perf_load_use)) perf_load_use <= perf_load_use + 32'd1;
      if (flush && !(&perf_flush)) perf_flush <= perf_flush + 32'd1;
      if (freeze && !(&perf_mem_wait)) perf_mem_wait <= perf_mem_wait + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of pipeline_ctrl hazard arbitration, redirect, timeout and reset
module tb_pipeline_ctrl;
  import pipe_ctrl_pkg::*;
  logic clk = 0;
  logic reset_n = 0;
  int checks = 0;
  int errors = 0;
  pipeline_ctrl_if b ();
  pipeline_ctrl_if t ();
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] pb0, pb1, pb2, pt0, pt1, pt2;
`endif
  pipeline_ctrl dut (
    .clk(clk), .reset_n(reset_n), .bus(b)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_load_use(pb0), .perf_flush(pb1), .perf_mem_wait(pb2)
`endif
  );
  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut_t (
    .clk(clk), .reset_n(reset_n), .bus(t)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_load_use(pt0), .perf_flush(pt1), .perf_mem_wait(pt2)
`endif
  );
  always #5 clk = ~clk;
  // output vectors: {stall_if, flush_if_id, bubble_id_ex, stall_id_ex, stall_ex_mem, bubble_mem_wb, mem_timeout}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] FRZ = 7'b1001110;
  localparam logic [6:0] BR = 7'b0110000;
  localparam logic [6:0] LU = 7'b1010000;
  localparam logic [6:0] FL = 7'b0100000;
  localparam logic [6:0] TO = 7'b0000011;
  function automatic logic [6:0] ob();
    return {b.stall_if, b.flush_if_id, b.bubble_id_ex, b.stall_id_ex, b.stall_ex_mem, b.bubble_mem_wb, b.mem_timeout};
  endfunction
  function automatic logic [6:0] ot();
    return {t.stall_if, t.flush_if_id, t.bubble_id_ex, t.stall_id_ex, t.stall_ex_mem, t.bubble_mem_wb, t.mem_timeout};
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic clr_b();
    b.id_valid = 0; b.id_rs1 = 0; b.id_rs2 = 0; b.id_uses_rs1 = 0; b.id_uses_rs2 = 0;
    b.ex_valid = 0; b.ex_mem_read = 0; b.ex_rd = 0; b.ex_branch_taken = 0;
    b.imem_ready = 1; b.mem_req = 0; b.mem_ack = 0;
  endtask
  task automatic set_lu(input logic [4:0] rd);
    b.ex_valid = 1; b.ex_mem_read = 1; b.ex_rd = rd;
    b.id_valid = 1; b.id_rs1 = rd; b.id_uses_rs1 = 1;
  endtask
  initial begin
    clr_b();
    t.id_valid = 0; t.id_rs1 = 0; t.id_rs2 = 0; t.id_uses_rs1 = 0; t.id_uses_rs2 = 0;
    t.ex_valid = 0; t.ex_mem_read = 0; t.ex_rd = 0; t.ex_branch_taken = 0;
    t.imem_ready = 1; t.mem_req = 0; t.mem_ack = 0;
    b.mem_req = 1; b.ex_branch_taken = 1;
    #1 chk("reset_outs", 32'(ob()), 32'(NONE));
    tick();
    tick();
    clr_b();
    reset_n = 1;
    #1 chk("reset_state", 32'(dut.state), 32'(RUN));
    chk("reset_cnt", 32'(dut.wait_cnt), 0);
    chk("idle_outs", 32'(ob()), 32'(NONE));
    tick();
    set_lu(5'd5);
    #1 chk("lu_rs1", 32'(ob()), 32'(LU));
    tick();
    b.ex_mem_read = 0;
    #1 chk("lu_cleared", 32'(ob()), 32'(NONE));
    tick();
    set_lu(5'd0);
    #1 chk("lu_x0", 32'(ob()), 32'(NONE));
    tick();
    clr_b();
    b.ex_valid = 1; b.ex_mem_read = 1; b.ex_rd = 5'd7;
    b.id_valid = 1; b.id_rs2 = 5'd7; b.id_uses_rs2 = 1;
    #1 chk("lu_rs2", 32'(ob()), 32'(LU));
    b.id_uses_rs2 = 0;
    #1 chk("lu_rs2_unused", 32'(ob()), 32'(NONE));
    tick();
    clr_b();
    b.ex_branch_taken = 1; b.imem_ready = 0;
    #1 chk("br_c0", 32'(ob()), 32'(BR));
    tick();
    b.ex_branch_taken = 0;
    set_lu(5'd3);
    #1 chk("br_state_redirect", 32'(dut.state), 32'(REDIRECT));
    chk("br_c1_lu_ignored", 32'(ob()), 32'(FL));
    tick();
    clr_b();
    b.imem_ready = 0;
    #1 chk("br_c2", 32'(ob()), 32'(FL));
    tick();
    b.imem_ready = 1;
    #1 chk("br_c3_ready", 32'(ob()), 32'(FL));
    tick();
    #1 chk("br_state_run", 32'(dut.state), 32'(RUN));
    chk("br_done", 32'(ob()), 32'(NONE));
    tick();
    b.mem_req = 1;
    for (int i = 0; i < 5; i++) begin
      #1 chk($sformatf("memwait_c%0d", i), 32'(ob()), 32'(FRZ));
      tick();
    end
    chk("memwait_cnt", 32'(dut.wait_cnt), 5);
    b.mem_ack = 1;
    #1 chk("memwait_ack", 32'(ob()), 32'(NONE));
    tick();
    clr_b();
    #1 chk("memwait_cnt_clr", 32'(dut.wait_cnt), 0);
    b.mem_req = 1; b.ex_branch_taken = 1; b.imem_ready = 1;
    set_lu(5'd9);
    #1 chk("prio_freeze", 32'(ob()), 32'(FRZ));
    tick();
    b.mem_ack = 1;
    #1 chk("prio_ack_branch", 32'(ob()), 32'(BR));
    tick();
    clr_b();
    #1 chk("prio_state", 32'(dut.state), 32'(RUN));
    t.mem_req = 1;
    for (int i = 1; i <= 3; i++) begin
      #1 chk($sformatf("to_freeze_c%0d", i), 32'(ot()), 32'(FRZ));
      tick();
    end
    #1 chk("to_pulse", 32'(ot()), 32'(TO));
    tick();
    #1 chk("to_restart", 32'(ot()), 32'(FRZ));
    chk("to_restart_cnt", 32'(dut_t.wait_cnt), 0);
    tick();
    t.mem_req = 0;
    tick();
    b.ex_branch_taken = 1; b.imem_ready = 0;
    t.mem_req = 1;
    #1 chk("rst_pre_br", 32'(ob()), 32'(BR));
    tick();
    b.ex_branch_taken = 0;
    #1 chk("rst_pre_redirect", 32'(ob()), 32'(FL));
    tick();
    #1 chk("rst_pre_cnt", 32'(dut_t.wait_cnt), 2);
    reset_n = 0;
    #1 chk("rst_b_outs", 32'(ob()), 32'(NONE));
    chk("rst_t_outs", 32'(ot()), 32'(NONE));
    chk("rst_b_state", 32'(dut.state), 32'(RUN));
    chk("rst_t_cnt", 32'(dut_t.wait_cnt), 0);
    tick();
    reset_n = 1;
    #1 chk("rst_rel_b", 32'(ob()), 32'(NONE));
    chk("rst_rel_t_no_to", 32'(ot()), 32'(FRZ));
    tick();
    #1 chk("rst_rel_t_c2", 32'(ot()), 32'(FRZ));
    chk("rst_rel_t_cnt", 32'(dut_t.wait_cnt), 1);
    t.mem_req = 0;
    clr_b();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
